// File: rtl/avalon_regbank_if.sv
// Avalon-MM bus bundle between the vidor_sys fabric (master) and avalon_regbank (slave).
interface avalon_regbank_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              read;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, write, writedata, byteenable, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, writedata, byteenable, read,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avalon_regbank.sv
// Board ID / switch / debug / cycle-counter / loopback register bank on Avalon-MM.
// Define AVALON_REGBANK_SWIRQ_EN to add the IRQ_STAT register and the switch-change irq.
module avalon_regbank #(
  parameter int          NUM_REGS        = 16,
  parameter int          ADDR_W          = 16,
  parameter int          ADDR_SHIFT      = 8,
  parameter int          SW_W            = 4,
  parameter logic [31:0] ID_VALUE        = 32'h5649_4430,
  parameter int          DEBOUNCE_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset,
  avalon_regbank_if.slave    avalon_slave,
  input  logic [SW_W-1:0]    sw,
  output logic               debug_out1,
  output logic               irq
);

  localparam int DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LOOP_BASE = 5;

  localparam logic [ADDR_W-1:0] IDX_ID   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] IDX_SW   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_CTRL = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] IDX_CNT  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] IDX_IRQ  = ADDR_W'(4);

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  logic [0:0]        state;
  logic [31:0]       readdata_q;
  logic [31:0]       rd_mux;
  logic [ADDR_W-1:0] index;
  logic              wr_accept;
  logic              ctrl;
  logic [31:0]       cnt;
  logic [31:0]       loop_regs [NUM_REGS];

  logic [SW_W-1:0]   sync1, sync2, cand, sw_q;
  logic [DB_W-1:0]   db_cnt, db_next;
  logic              sw_update;

  assign index     = avalon_slave.address >> ADDR_SHIFT;
  assign avalon_slave.waitrequest = (state == ST_WAIT) && avalon_slave.read;
  assign avalon_slave.readdata    = readdata_q;
  // A read+write pair is stalled in WAIT, so the write lands in the DONE cycle.
  assign wr_accept  = avalon_slave.write && !avalon_slave.waitrequest;
  assign debug_out1 = ctrl;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
    return r;
  endfunction

`ifdef AVALON_REGBANK_SWIRQ_EN
  logic pending;
  logic irq_clear;

  assign irq_clear = wr_accept && (index == IDX_IRQ) &&
                     avalon_slave.byteenable[0] && avalon_slave.writedata[0];
  assign irq       = pending;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          pending <= 1'b0;
    else if (sw_update) pending <= 1'b1;
    else if (irq_clear) pending <= 1'b0;
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    // NOTE: default first so every path assigns rd_mux and no latch is inferred.
    rd_mux = 32'hDEAD_BEEF;
    if (index == IDX_ID)        rd_mux = ID_VALUE;
    else if (index == IDX_SW)   rd_mux = 32'(sw_q);
    else if (index == IDX_CTRL) rd_mux = {31'b0, ctrl};
    else if (index == IDX_CNT)  rd_mux = cnt;
`ifdef AVALON_REGBANK_SWIRQ_EN
    else if (index == IDX_IRQ)  rd_mux = {31'b0, pending};
`endif
    else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (index == ADDR_W'(LOOP_BASE + i)) rd_mux = loop_regs[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_WAIT;
      readdata_q <= '0;
    end else if (state == ST_WAIT) begin
      if (avalon_slave.read) begin
        readdata_q <= rd_mux;
        state      <= ST_DONE;
      end
    end else begin
      state <= ST_WAIT;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 cnt <= '0;
    else if (wr_accept && (index == IDX_CNT))  cnt <= '0;
    else                                       cnt <= cnt + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      ctrl <= 1'b0;
    else if (wr_accept && (index == IDX_CTRL) && avalon_slave.byteenable[0])
      ctrl <= avalon_slave.writedata[0];
  end

  // NOTE: the loopback array is a bank of flops, not a RAM, so resetting it is legitimate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) loop_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_accept && (index == ADDR_W'(LOOP_BASE + i)))
          loop_regs[i] <= merge_lanes(loop_regs[i], avalon_slave.writedata,
                                      avalon_slave.byteenable);
    end
  end

  // db_next counts consecutive observations of the same candidate, this cycle included.
  assign db_next   = ((sync2 == cand) && (db_cnt != '0)) ? db_cnt + DB_W'(1) : DB_W'(1);
  assign sw_update = (sync2 != sw_q) && (db_next == DB_W'(DEBOUNCE_CYCLES));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      sw_q   <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      cand  <= sync2;
      if (sync2 == sw_q) begin
        db_cnt <= '0;
      end else if (sw_update) begin
        sw_q   <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_next;
      end
    end
  end

endmodule

// File: tb/tb_avalon_regbank.sv
// Self-checking bench for avalon_regbank: register-map vector table plus handshake,
// counter, switch-debounce and (with AVALON_REGBANK_SWIRQ_EN) irq sequences.
module tb_avalon_regbank;

  localparam int DEB = 8;
`ifdef AVALON_REGBANK_SWIRQ_EN
  localparam logic [31:0] SWIRQ = 32'd1;
`else
  localparam logic [31:0] SWIRQ = 32'd0;
`endif

  logic       clock;
  logic       reset;
  logic [3:0] sw;
  logic       debug_out1;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  avalon_regbank_if #(.ADDR_W(16)) bus ();

  avalon_regbank #(
    .NUM_REGS(16), .ADDR_W(16), .ADDR_SHIFT(8), .SW_W(4),
    .ID_VALUE(32'h5649_4430), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock(clock), .reset(reset), .avalon_slave(bus),
    .sw(sw), .debug_out1(debug_out1), .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus.address    = addr;
    bus.writedata  = data;
    bus.byteenable = be;
    bus.write      = 1'b1;
    @(negedge clock);
    bus.write      = 1'b0;
    bus.byteenable = 4'b0000;
  endtask

  // Expected value is queued when the read is issued and popped when readdata is valid.
  task automatic check_read(input string name, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] got;
    int lat;
    exp_q.push_back(exp);
    bus.address = addr;
    bus.read    = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (bus.waitrequest && lat < 8);
    check({name, "_latency"}, 32'(lat), 32'd1);
    got = bus.readdata;
    bus.read = 1'b0;
    check(name, got, exp_q.pop_front());
    @(negedge clock);
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [21];

  initial begin
    vecs[0]  = '{0, 16'h0000, 32'h0,         4'h0,    32'h5649_4430};
    vecs[1]  = '{1, 16'h0500, 32'hAABB_CCDD, 4'b0101, 32'h0};
    vecs[2]  = '{0, 16'h0500, 32'h0,         4'h0,    32'h00BB_00DD};
    vecs[3]  = '{0, 16'h7F00, 32'h0,         4'h0,    32'hDEAD_BEEF};
    vecs[4]  = '{1, 16'h0500, 32'h1122_3344, 4'b0000, 32'h0};
    vecs[5]  = '{0, 16'h0500, 32'h0,         4'h0,    32'h00BB_00DD};
    vecs[6]  = '{1, 16'h0500, 32'h1122_3344, 4'b1010, 32'h0};
    vecs[7]  = '{0, 16'h0500, 32'h0,         4'h0,    32'h11BB_33DD};
    vecs[8]  = '{1, 16'h1400, 32'hCAFE_F00D, 4'b1111, 32'h0};
    vecs[9]  = '{0, 16'h1400, 32'h0,         4'h0,    32'hCAFE_F00D};
    vecs[10] = '{0, 16'h1500, 32'h0,         4'h0,    32'hDEAD_BEEF};
    vecs[11] = '{1, 16'h1500, 32'h1234_5678, 4'b1111, 32'h0};
    vecs[12] = '{0, 16'h1500, 32'h0,         4'h0,    32'hDEAD_BEEF};
    vecs[13] = '{0, 16'h0600, 32'h0,         4'h0,    32'h0};
    vecs[14] = '{0, 16'h0540, 32'h0,         4'h0,    32'h11BB_33DD};
    vecs[15] = '{1, 16'h0000, 32'hFFFF_FFFF, 4'b1111, 32'h0};
    vecs[16] = '{0, 16'h0000, 32'h0,         4'h0,    32'h5649_4430};
    vecs[17] = '{1, 16'h0200, 32'hFFFF_FFFF, 4'b1111, 32'h0};
    vecs[18] = '{0, 16'h0200, 32'h0,         4'h0,    32'h0000_0001};
    vecs[19] = '{1, 16'h0200, 32'h0,         4'b0001, 32'h0};
    vecs[20] = '{0, 16'h0200, 32'h0,         4'h0,    32'h0};

    reset          = 1'b1;
    sw             = 4'h0;
    bus.address    = '0;
    bus.write      = 1'b0;
    bus.writedata  = '0;
    bus.byteenable = 4'b0000;
    bus.read       = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_waitrequest_idle", 32'(bus.waitrequest), 32'd0);
    check("rst_debug_out1", 32'(debug_out1), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    bus.read = 1'b1;
    #1 check("rst_waitrequest_follows_read", 32'(bus.waitrequest), 32'd1);
    bus.read = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // First read: waitrequest must be high in the issue cycle.
    bus.address = 16'h0000;
    bus.read    = 1'b1;
    #1 check("id_wait_first_cycle", 32'(bus.waitrequest), 32'd1);
    bus.read    = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 21; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data, vecs[i].be);
      else            check_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // debug_out1 follows CTRL bit0 right after the accepting edge.
    bus_write(16'h0200, 32'h1, 4'b0001);
    check("debug_high", 32'(debug_out1), 32'd1);
    bus_write(16'h0200, 32'h0, 4'b0000);
    check("debug_be0_keeps", 32'(debug_out1), 32'd1);
    bus_write(16'h0200, 32'h0, 4'b0001);
    check("debug_low", 32'(debug_out1), 32'd0);

    // CNT clear (byteenable ignored) then read 10 cycles later.
    bus_write(16'h0300, 32'h1234, 4'b0000);
    repeat (10) @(negedge clock);
    check_read("cnt_after_clear", 16'h0300, 32'd10);

    // Wrap: hold counter at all-ones, then observe 0xFFFFFFFF followed by a wrapped value.
    force dut.cnt = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.cnt;
    check_read("cnt_max", 16'h0300, 32'hFFFF_FFFF);
    check_read("cnt_wrapped", 16'h0300, 32'd1);

    // Read and write together on LOOP1: read sees old data, write lands in DONE.
    bus.address    = 16'h0600;
    bus.writedata  = 32'h1357_2468;
    bus.byteenable = 4'b1111;
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    #1 check("rw_wait_first", 32'(bus.waitrequest), 32'd1);
    @(negedge clock);
    check("rw_wait_done", 32'(bus.waitrequest), 32'd0);
    check("rw_read_old", bus.readdata, 32'h0);
    @(negedge clock);
    bus.read  = 1'b0;
    bus.write = 1'b0;
    check_read("rw_write_taken", 16'h0600, 32'h1357_2468);

    // Switch debounce: the update lands exactly 2 + DEB edges after the change.
    sw = 4'hA;
    repeat (9) @(negedge clock);
    check_read("sw_not_yet", 16'h0100, 32'h0);
    check_read("sw_settled", 16'h0100, 32'hA);
    check("irq_on_change", 32'(irq), SWIRQ);
`ifdef AVALON_REGBANK_SWIRQ_EN
    check_read("irq_stat_set", 16'h0400, 32'h1);
    bus_write(16'h0400, 32'h1, 4'b0000);
    check("irq_be0_keeps", 32'(irq), 32'd1);
    bus_write(16'h0400, 32'h1, 4'b0001);
    check("irq_cleared", 32'(irq), 32'd0);
    check_read("irq_stat_clr", 16'h0400, 32'h0);
`else
    check_read("idx4_unmapped", 16'h0400, 32'hDEAD_BEEF);
    bus_write(16'h0400, 32'h1, 4'b1111);
    check("irq_tied", 32'(irq), 32'd0);
`endif

    sw = 4'h0;
    repeat (10) @(negedge clock);
    check_read("sw_back_zero", 16'h0100, 32'h0);
    bus_write(16'h0400, 32'h1, 4'b0001);
    check("irq_clear2", 32'(irq), 32'd0);

    // Clear in the same cycle as a new change: set wins.
    sw = 4'hA;
    repeat (9) @(negedge clock);
    bus_write(16'h0400, 32'h1, 4'b0001);
    check("irq_set_wins", 32'(irq), SWIRQ);
    bus_write(16'h0400, 32'h1, 4'b0001);
    check("irq_clear3", 32'(irq), 32'd0);

    // Glitch shorter than DEB cycles is rejected.
    sw = 4'h5;
    repeat (7) @(negedge clock);
    sw = 4'hA;
    repeat (20) @(negedge clock);
    check_read("sw_glitch_rejected", 16'h0100, 32'hA);
    check("irq_glitch", 32'(irq), 32'd0);

    // Reset in the DONE cycle of a read.
    bus.address = 16'h0500;
    bus.read    = 1'b1;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_waitrequest", 32'(bus.waitrequest), 32'd1);
    check("midrst_readdata", bus.readdata, 32'h0);
    @(negedge clock);
    check("midrst_wait_held", 32'(bus.waitrequest), 32'd1);
    reset    = 1'b0;
    bus.read = 1'b0;
    @(negedge clock);
    check_read("loop0_after_reset", 16'h0500, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
